// File: rtl/store_drain_buffer_if.sv
// Store/load/response/datamem bundle of store_drain_buffer.
// The slave modport is the buffer; the master modport is the LSU + datamem side.
interface store_drain_buffer_if #(
  parameter int TAG_W = 6
);
  logic             st_valid;
  logic             st_ready;
  logic [31:0]      st_addr;
  logic [31:0]      st_data;
  logic [3:0]       st_size;

  logic             ld_valid;
  logic             ld_ready;
  logic [31:0]      ld_addr;
  logic [3:0]       ld_size;
  logic [TAG_W-1:0] ld_tag;

  logic             ld_resp_valid;
  logic [31:0]      ld_resp_data;
  logic [TAG_W-1:0] ld_resp_tag;

  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic [3:0]       mem_size;
  logic             mem_we;
  logic             mem_re;
  logic [31:0]      mem_rdata;

  modport slave (
    input  st_valid, st_addr, st_data, st_size,
    output st_ready,
    input  ld_valid, ld_addr, ld_size, ld_tag,
    output ld_ready,
    output ld_resp_valid, ld_resp_data, ld_resp_tag,
    output mem_addr, mem_wdata, mem_size, mem_we, mem_re,
    input  mem_rdata
  );

  modport master (
    output st_valid, st_addr, st_data, st_size,
    input  st_ready,
    output ld_valid, ld_addr, ld_size, ld_tag,
    input  ld_ready,
    input  ld_resp_valid, ld_resp_data, ld_resp_tag,
    input  mem_addr, mem_wdata, mem_size, mem_we, mem_re,
    output mem_rdata
  );
endinterface

// File: rtl/store_drain_buffer.sv
// Committed-store FIFO and load arbiter in front of datamem; loads win the port unless they hit a buffered store.
// Optional macro STORE_FWD_EN: exact addr/size match on the youngest overlapping store forwards its data.
module store_drain_buffer #(
  parameter int DEPTH = 8,
  parameter int TAG_W = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  store_drain_buffer_if.slave    bus,
  output logic [$clog2(DEPTH):0] sb_count,
  output logic                   sb_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  size;
  } entry_t;

  typedef enum logic [1:0] {PORT_IDLE, PORT_LOAD, PORT_DRAIN} port_op_e;

  entry_t           sb_q [DEPTH];
  logic [PTR_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] count_q;
  logic             resp_valid_q;
  logic [31:0]      resp_data_q;
  logic [TAG_W-1:0] resp_tag_q;

  logic             full, ovl_found, ld_hazard, fwd_hit, ld_grant, enq, drain;
  logic [31:0]      fwd_data, load_value;
  entry_t           head_entry;
  port_op_e         port_op;
`ifdef STORE_FWD_EN
  logic [PTR_W-1:0] ovl_idx;
`endif

  function automatic logic [31:0] size_mask(input logic [3:0] size);
    case (size)
      4'd1:    return 32'h0000_00FF;
      4'd2:    return 32'h0000_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  // Half-open byte ranges [a, a+s) intersect; 33 bits so the end address cannot wrap.
  function automatic logic overlaps(input logic [31:0] a1, input logic [3:0] s1,
                                    input logic [31:0] a2, input logic [3:0] s2);
    logic [32:0] end1, end2;
    end1 = {1'b0, a1} + 33'(s1);
    end2 = {1'b0, a2} + 33'(s2);
    return ({1'b0, a1} < end2) && ({1'b0, a2} < end1);
  endfunction

  function automatic logic legal_access(input logic [31:0] addr, input logic [3:0] size);
    logic aligned;
    case (size)
      4'd1:    aligned = 1'b1;
      4'd2:    aligned = ~addr[0];
      4'd4:    aligned = (addr[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
    return aligned && (addr[31:15] == 17'h1_0000);
  endfunction

  assign full       = (count_q == CNT_W'(DEPTH));
  assign head_entry = sb_q[head_q];

  // Walk valid entries oldest to youngest so the last match is the youngest overlapping store.
  // NOTE: every variable written here gets a default first, otherwise a latch is inferred.
  always_comb begin
    ovl_found = 1'b0;
    ld_hazard = 1'b0;
    fwd_hit   = 1'b0;
    fwd_data  = '0;
`ifdef STORE_FWD_EN
    ovl_idx   = '0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      if (CNT_W'(k) < count_q &&
          overlaps(sb_q[head_q + PTR_W'(k)].addr, sb_q[head_q + PTR_W'(k)].size,
                   bus.ld_addr, bus.ld_size)) begin
        ovl_found = 1'b1;
`ifdef STORE_FWD_EN
        ovl_idx   = head_q + PTR_W'(k);
`endif
      end
    end
`ifdef STORE_FWD_EN
    if (ovl_found) begin
      if (sb_q[ovl_idx].addr == bus.ld_addr && sb_q[ovl_idx].size == bus.ld_size) begin
        fwd_hit  = 1'b1;
        fwd_data = sb_q[ovl_idx].data;
      end else begin
        ld_hazard = 1'b1;
      end
    end
`else
    ld_hazard = ovl_found;
`endif
  end

  // A full buffer withholds the grant so the head store always makes progress.
  assign ld_grant = bus.ld_valid && !ld_hazard && !full;

  // A forwarded load never touches datamem, leaving the port free for a drain.
  always_comb begin
    port_op = PORT_IDLE;
    if (ld_grant && !fwd_hit) port_op = PORT_LOAD;
    else if (count_q != '0)   port_op = PORT_DRAIN;
  end

  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_size  = '0;
    bus.mem_we    = 1'b0;
    bus.mem_re    = 1'b0;
    unique case (port_op)
      PORT_LOAD: begin
        bus.mem_addr = bus.ld_addr;
        bus.mem_size = bus.ld_size;
        bus.mem_re   = 1'b1;
      end
      PORT_DRAIN: begin
        bus.mem_addr  = head_entry.addr;
        bus.mem_wdata = head_entry.data;
        bus.mem_size  = head_entry.size;
        bus.mem_we    = 1'b1;
      end
      default: ;
    endcase
  end

  assign enq        = bus.st_valid && !full;
  assign drain      = (port_op == PORT_DRAIN);
  assign load_value = fwd_hit ? fwd_data : bus.mem_rdata;

  assign bus.st_ready      = !full;
  assign bus.ld_ready      = ld_grant;
  assign bus.ld_resp_valid = resp_valid_q;
  assign bus.ld_resp_data  = resp_data_q;
  assign bus.ld_resp_tag   = resp_tag_q;
  assign sb_count          = count_q;
  assign sb_empty          = (count_q == '0);

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_tag_q   <= '0;
    end else begin
      if (enq)   tail_q <= tail_q + PTR_W'(1);
      if (drain) head_q <= head_q + PTR_W'(1);
      count_q      <= count_q + CNT_W'(enq) - CNT_W'(drain);
      resp_valid_q <= ld_grant;
      if (ld_grant) begin
        resp_data_q <= load_value & size_mask(bus.ld_size);
        resp_tag_q  <= bus.ld_tag;
      end
    end
  end

  // NOTE: entry storage has no reset; count_q alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (enq) sb_q[tail_q] <= {bus.st_addr, bus.st_data, bus.st_size};
  end

  a_st_legal: assert property (@(posedge clk) disable iff (!rst_n)
    bus.st_valid |-> legal_access(bus.st_addr, bus.st_size));
  a_ld_legal: assert property (@(posedge clk) disable iff (!rst_n)
    bus.ld_valid |-> legal_access(bus.ld_addr, bus.ld_size));
  a_port_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(bus.mem_we && bus.mem_re));

endmodule

// File: tb/tb_store_drain_buffer.sv
// Directed bench for store_drain_buffer: byte-wide datamem model, write log, hand-computed expectations.
// Expectations that depend on STORE_FWD_EN follow the same macro.
module tb_store_drain_buffer;
  localparam int DEPTH = 8;
  localparam int TAG_W = 6;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sb_count;
  logic       sb_empty;
  int         n_checks = 0;
  int         n_fail   = 0;

  store_drain_buffer_if #(.TAG_W(TAG_W)) bus ();

  store_drain_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .sb_count (sb_count),
    .sb_empty (sb_empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  size;
  } wr_t;

  wr_t         wlog[$];
  logic [7:0]  dmem [32768] = '{default: 8'h00};
  logic [14:0] ra;

  assign ra            = bus.mem_addr[14:0];
  assign bus.mem_rdata = {dmem[ra + 15'd3], dmem[ra + 15'd2], dmem[ra + 15'd1], dmem[ra]};

  always @(posedge clk) begin
    if (bus.mem_we) begin
      for (int b = 0; b < 4; b++)
        if (b < int'(bus.mem_size)) dmem[bus.mem_addr[14:0] + 15'(b)] <= bus.mem_wdata[8*b +: 8];
      wlog.push_back('{bus.mem_addr, bus.mem_wdata, bus.mem_size});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic put_store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] size);
    bus.st_valid = 1'b1;
    bus.st_addr  = addr;
    bus.st_data  = data;
    bus.st_size  = size;
  endtask

  task automatic put_load(input logic [31:0] addr, input logic [3:0] size, input logic [5:0] tag);
    bus.ld_valid = 1'b1;
    bus.ld_addr  = addr;
    bus.ld_size  = size;
    bus.ld_tag   = tag;
  endtask

  // Returns at the negedge of the granting cycle; waited = cycles spent before the grant.
  task automatic wait_grant(input string tag, input int exp_wait);
    int waited = 0;
    @(negedge clk);
    while (!bus.ld_ready && waited < 30) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_granted"}, 32'(bus.ld_ready), 32'd1);
    check({tag, "_wait"}, 32'(waited), 32'(exp_wait));
  endtask

  task automatic drain_all(input string tag);
    int n = 0;
    while (!sb_empty && n < 40) begin
      tick();
      n++;
    end
    check(tag, 32'(sb_empty), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int exp_wait_exact, exp_wait_dup, exp_re_exact;
`ifdef STORE_FWD_EN
    exp_wait_exact = 0; exp_wait_dup = 0; exp_re_exact = 0;
`else
    exp_wait_exact = 1; exp_wait_dup = 2; exp_re_exact = 1;
`endif
    bus.st_valid = 1'b0; bus.st_addr = 32'h8000_0000; bus.st_data = '0; bus.st_size = 4'd4;
    bus.ld_valid = 1'b0; bus.ld_addr = 32'h8000_0000; bus.ld_size = 4'd4; bus.ld_tag = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) tick();
    check("rst_count", 32'(sb_count), 32'd0);
    check("rst_empty", 32'(sb_empty), 32'd1);
    check("rst_resp_valid", 32'(bus.ld_resp_valid), 32'd0);
    check("rst_resp_data", bus.ld_resp_data, 32'd0);
    check("rst_resp_tag", 32'(bus.ld_resp_tag), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_mem_re", 32'(bus.mem_re), 32'd0);
    rst_n = 1'b1;
    tick();
    check("idle_st_ready", 32'(bus.st_ready), 32'd1);

    // Three stores held in the buffer by a non-overlapping load, then reset mid-cycle.
    put_load(32'h8000_1000, 4'd4, 6'd1);
    for (int i = 0; i < 3; i++) begin
      put_store(32'h8000_0100 + 32'(4 * i), 32'h0101_0101 * 32'(i + 1), 4'd4);
      tick();
    end
    bus.st_valid = 1'b0;
    check("t1_count3", 32'(sb_count), 32'd3);
    check("t1_load_holds_port", 32'(bus.mem_re), 32'd1);
    check("t1_resp_tag", 32'(bus.ld_resp_tag), 32'd1);
    base = wlog.size();
    bus.ld_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check("t1_rst_count", 32'(sb_count), 32'd0);
    check("t1_rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("t1_rst_resp_valid", 32'(bus.ld_resp_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("t1_no_writes", 32'(wlog.size() - base), 32'd0);

    // Single store drains on the next cycle, then a load reads it back.
    put_store(32'h8000_0010, 32'hDEAD_BEEF, 4'd4);
    tick();
    bus.st_valid = 1'b0;
    check("t2_count1", 32'(sb_count), 32'd1);
    @(negedge clk);
    check("t2_mem_we", 32'(bus.mem_we), 32'd1);
    check("t2_mem_addr", bus.mem_addr, 32'h8000_0010);
    check("t2_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    tick();
    check("t2_drained", 32'(sb_count), 32'd0);
    put_load(32'h8000_0010, 4'd4, 6'h2A);
    wait_grant("t2_load", 0);
    check("t2_mem_re", 32'(bus.mem_re), 32'd1);
    tick();
    bus.ld_valid = 1'b0;
    check("t2_resp_valid", 32'(bus.ld_resp_valid), 32'd1);
    check("t2_resp_data", bus.ld_resp_data, 32'hDEAD_BEEF);
    check("t2_resp_tag", 32'(bus.ld_resp_tag), 32'h2A);
    tick();
    check("t2_resp_one_cycle", 32'(bus.ld_resp_valid), 32'd0);

    // Fill to DEPTH behind a continuous load; full forces a drain instead of the load.
    base = wlog.size();
    put_load(32'h8000_2000, 4'd4, 6'd7);
    for (int i = 0; i < DEPTH; i++) begin
      put_store(32'h8000_0200 + 32'(4 * i), 32'h100 + 32'(i), 4'd4);
      tick();
    end
    put_store(32'h8000_0220, 32'h108, 4'd4);
    check("t3_count_full", 32'(sb_count), 32'd8);
    @(negedge clk);
    check("t3_st_ready_full", 32'(bus.st_ready), 32'd0);
    check("t3_ld_ready_full", 32'(bus.ld_ready), 32'd0);
    check("t3_drain_we", 32'(bus.mem_we), 32'd1);
    check("t3_drain_no_re", 32'(bus.mem_re), 32'd0);
    check("t3_drain_head", bus.mem_addr, 32'h8000_0200);
    tick();
    check("t3_count7", 32'(sb_count), 32'd7);
    @(negedge clk);
    check("t3_st_ready_again", 32'(bus.st_ready), 32'd1);
    check("t3_load_resumes", 32'(bus.mem_re), 32'd1);
    tick();
    bus.st_valid = 1'b0;
    bus.ld_valid = 1'b0;
    check("t3_count_refill", 32'(sb_count), 32'd8);
    drain_all("t3_drain_done");
    check("t3_write_count", 32'(wlog.size() - base), 32'd9);
    check("t3_last_addr", wlog[wlog.size() - 1].addr, 32'h8000_0220);

    // Partial overlap always waits; exact match forwards only with STORE_FWD_EN.
    put_store(32'h8000_0020, 32'h1122_3344, 4'd4);
    tick();
    bus.st_valid = 1'b0;
    put_load(32'h8000_0021, 4'd1, 6'd3);
    wait_grant("t4_partial", 1);
    tick();
    bus.ld_valid = 1'b0;
    check("t4_partial_data", bus.ld_resp_data, 32'h0000_0033);
    check("t4_partial_tag", 32'(bus.ld_resp_tag), 32'd3);
    put_store(32'h8000_0020, 32'h1122_3344, 4'd4);
    tick();
    bus.st_valid = 1'b0;
    put_load(32'h8000_0020, 4'd4, 6'd4);
    wait_grant("t4_exact", exp_wait_exact);
    check("t4_exact_mem_re", 32'(bus.mem_re), 32'(exp_re_exact));
    tick();
    bus.ld_valid = 1'b0;
    check("t4_exact_data", bus.ld_resp_data, 32'h1122_3344);
    check("t4_exact_tag", 32'(bus.ld_resp_tag), 32'd4);
    check("t4_count0", 32'(sb_count), 32'd0);

    // Two byte stores to one address; the load must see the younger one.
    put_load(32'h8000_3000, 4'd4, 6'd9);
    put_store(32'h8000_0040, 32'h0000_00AA, 4'd1);
    tick();
    put_store(32'h8000_0040, 32'h0000_00BB, 4'd1);
    tick();
    bus.st_valid = 1'b0;
    check("t5_count2", 32'(sb_count), 32'd2);
    put_load(32'h8000_0040, 4'd1, 6'd5);
    wait_grant("t5_dup", exp_wait_dup);
    tick();
    bus.ld_valid = 1'b0;
    check("t5_data_youngest", bus.ld_resp_data, 32'h0000_00BB);
    check("t5_tag", 32'(bus.ld_resp_tag), 32'd5);
    drain_all("t5_drain_done");

    // Steady enqueue+drain at occupancy 4 across several pointer wraps.
    base = wlog.size();
    put_load(32'h8000_4000, 4'd4, 6'd11);
    for (int i = 0; i < 4; i++) begin
      put_store(32'h8000_0300 + 32'(4 * i), 32'hC000_0000 + 32'(i), 4'd4);
      tick();
    end
    bus.ld_valid = 1'b0;
    for (int i = 4; i < 24; i++) begin
      put_store(32'h8000_0300 + 32'(4 * i), 32'hC000_0000 + 32'(i), 4'd4);
      tick();
      check("t6_count_steady", 32'(sb_count), 32'd4);
    end
    bus.st_valid = 1'b0;
    drain_all("t6_drain_done");
    check("t6_write_count", 32'(wlog.size() - base), 32'd24);
    for (int i = 0; i < 24; i++) begin
      if (base + i < wlog.size()) begin
        check("t6_order_addr", wlog[base + i].addr, 32'h8000_0300 + 32'(4 * i));
        check("t6_order_data", wlog[base + i].data, 32'hC000_0000 + 32'(i));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
